result_tx_sequencer: RTL

//  Transmit side of the host matrix protocol. Compute phase ends; controller pulses start.

---
 rtl/result_tx_sequencer_pkg.sv | 18 +
 rtl/result_tx_sequencer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/result_tx_sequencer_pkg.sv
// Shared constants and FSM encodings for the result transmit sequencer.
// The state encodings are also used by the control unit.
package result_tx_sequencer_pkg;

  localparam int DEF_MAX_N = 8;
  localparam bit MSB_FIRST = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR    = 3'd1,
    S_FETCH  = 3'd2,
    S_RDWAIT = 3'd3,
    S_SEND   = 3'd4,
    S_TXWAIT = 3'd5,
    S_FIN    = 3'd6
  } state_t;

endpackage

// File: rtl/result_tx_sequencer.sv
// Streams a result frame ([N], then N*N elements MSB byte first) from result RAM
// to the UART TX byte interface, pulsing done (and size_err) at frame end.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | wait for start; latch N and N*N, clear counters
// S_HDR    | present header byte, issue tx_start once TX is idle
// S_FETCH  | read strobe for element elem_cnt
// S_RDWAIT | capture RAM data into the shift register
// S_SEND   | present current element byte, issue tx_start once TX is idle
// S_TXWAIT | wait for TX busy to rise then fall; pick next byte/element
// S_FIN    | one-cycle done (and size_err) pulse
module result_tx_sequencer
  import result_tx_sequencer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int MAX_N  = DEF_MAX_N,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        matrix_size,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done,
  output logic              size_err
);

  localparam int NBYTES = DATA_W / 8;
  localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);

  state_t            state, state_d;
  logic [3:0]        n_q;
  logic [7:0]        nn_q;
  logic [7:0]        elem_cnt;
  logic [BCW-1:0]    byte_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_next;
  logic [7:0]        tx_data_q;
  logic              hdr_q;
  logic              seen_q;
  logic              n_bad;
  logic              tx_done;
  logic              last_byte;
  logic              last_elem;

  assign n_bad      = (n_q == 4'd0) || (int'(n_q) > MAX_N);
  assign tx_done    = (state == S_TXWAIT) && seen_q && !tx_busy;
  assign last_byte  = (byte_cnt == LAST_BYTE);
  assign last_elem  = (elem_cnt == nn_q - 8'd1);
  assign shreg_next = shreg << 8;

  assign tx_data = tx_data_q;
  assign rd_addr = elem_cnt[ADDR_W-1:0];
  assign busy    = (state != S_IDLE);

  always_comb begin
    state_d  = state;
    tx_start = 1'b0;
    rd_en    = 1'b0;
    done     = 1'b0;
    size_err = 1'b0;
    case (state)
      S_IDLE:   if (start) state_d = S_HDR;
      S_HDR, S_SEND: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = S_TXWAIT;
        end
      end
      S_FETCH: begin
        rd_en   = 1'b1;
        state_d = S_RDWAIT;
      end
      S_RDWAIT: state_d = S_SEND;
      S_TXWAIT: begin
        if (tx_done) begin
          if (hdr_q)           state_d = n_bad ? S_FIN : S_FETCH;
          else if (!last_byte) state_d = S_SEND;
          else if (last_elem)  state_d = S_FIN;
          else                 state_d = S_FETCH;
        end
      end
      S_FIN: begin
        done     = 1'b1;
        size_err = (int'(n_q) > MAX_N);
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      n_q       <= '0;
      nn_q      <= '0;
      elem_cnt  <= '0;
      byte_cnt  <= '0;
      shreg     <= '0;
      tx_data_q <= '0;
      hdr_q     <= 1'b0;
      seen_q    <= 1'b0;
    end else begin
      state <= state_d;
      if (state == S_IDLE && start) begin
        n_q       <= matrix_size;
        nn_q      <= {4'h0, matrix_size} * {4'h0, matrix_size};
        elem_cnt  <= '0;
        byte_cnt  <= '0;
        hdr_q     <= 1'b1;
        tx_data_q <= {4'h0, matrix_size};
      end
      if (state == S_RDWAIT) begin
        shreg     <= rd_data;
        tx_data_q <= rd_data[DATA_W-1 -: 8];
      end
      // Busy must be seen high before its fall counts as end of this byte.
      if (state == S_TXWAIT && tx_busy) seen_q <= 1'b1;
      if (tx_done) begin
        seen_q <= 1'b0;
        if (hdr_q) begin
          hdr_q <= 1'b0;
        end else if (!last_byte) begin
          shreg     <= shreg_next;
          tx_data_q <= shreg_next[DATA_W-1 -: 8];
          byte_cnt  <= byte_cnt + 1'b1;
        end else if (!last_elem) begin
          elem_cnt <= elem_cnt + 8'd1;
          byte_cnt <= '0;
        end
      end
    end
  end

endmodule
